multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle combinational `Control` decoder in the MIPS datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a ready handshake.
- Supports parametrised memory wait-state timeout, sticky halt on exit syscall, illegal-instruction fault, and a retired-instruction counter.
- Sits between the instruction register (`op`/`funct` source) and the datapath muxes, register file, ALU and memory.

---
 rtl/multicycle_control_pkg.sv | 121 ++++++++++++
 rtl/multicycle_control_if.sv | 49 ++++
 rtl/multicycle_control_alu_decode.sv | 40 ++++
 rtl/multicycle_control.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit:
// FSM states, opcode/funct values, ALU operation codes, mux encodings
// and the R-type funct -> ALU operation table.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,  // ALU result (PC+4)
    PC_ALUOUT = 2'b01,  // registered branch target
    PC_JUMP   = 2'b10,  // {PC[31:28], target, 2'b00}
    PC_RS     = 2'b11   // register rs (jr)
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_RT     = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_e;

  // Full set of datapath control strobes, assembled in one place per state.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       bne_or_beq;
    pc_src_e    pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       is_jal;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    logic       zero_extend;
    alu_op_e    alu_op;
  } ctrl_t;

  typedef struct packed {
    logic    valid;
    alu_op_e op;
  } funct_entry_t;

  // R-type funct -> ALU operation; jr/syscall are not ALU ops and are absent.
  function automatic funct_entry_t funct_to_alu(input logic [5:0] funct);
    funct_entry_t e;
    e.valid = 1'b1;
    e.op    = ALU_ADD;
    case (funct)
      FN_ADD, FN_ADDU: e.op = ALU_ADD;
      FN_SUB, FN_SUBU: e.op = ALU_SUB;
      FN_AND:          e.op = ALU_AND;
      FN_OR:           e.op = ALU_OR;
      FN_XOR:          e.op = ALU_XOR;
      FN_NOR:          e.op = ALU_NOR;
      FN_SLT:          e.op = ALU_SLT;
      FN_SLL:          e.op = ALU_SLL;
      FN_SRL:          e.op = ALU_SRL;
      FN_SRA:          e.op = ALU_SRA;
      default:         e.valid = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control unit and the datapath: instruction fields and
// memory/register-file status in, control strobes and status out.
interface multicycle_control_if #(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               mem_ready;
  logic               syscall_exit;

  logic               pc_write;
  logic               pc_write_cond;
  logic               bne_or_beq;
  logic [1:0]         pc_src;
  logic               ir_write;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               is_jal;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic               zero_extend;
  logic [ALUOP_W-1:0] alu_op;
  logic               halted;
  logic               fault;
  logic [CNT_W-1:0]   instr_count;

  // Control unit side
  modport master (
    input  op, funct, mem_ready, syscall_exit,
    output pc_write, pc_write_cond, bne_or_beq, pc_src, ir_write, iord,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, is_jal,
           alu_src_a, alu_src_b, zero_extend, alu_op, halted, fault,
           instr_count
  );

  // Datapath side
  modport slave (
    output op, funct, mem_ready, syscall_exit,
    input  pc_write, pc_write_cond, bne_or_beq, pc_src, ir_write, iord,
           mem_read, mem_write, reg_write, reg_dst, mem_to_reg, is_jal,
           alu_src_a, alu_src_b, zero_extend, alu_op, halted, fault,
           instr_count
  );
endinterface

// File: rtl/multicycle_control_alu_decode.sv
// Combinational op/funct decode: ALU operation, immediate zero-extension and
// an illegal-instruction flag. Kept free of FSM state so a pipelined control
// can reuse it unchanged.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output logic       zero_extend,
  output logic       illegal
);

  funct_entry_t fe;

  // Classify the instruction and pick its ALU operation.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    fe          = funct_to_alu(funct);
    alu_op      = ALU_ADD;
    zero_extend = 1'b0;
    illegal     = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (fe.valid) alu_op = fe.op;
        else          illegal = !(funct == FN_JR || funct == FN_SYSCALL);
      end
      OP_J, OP_JAL, OP_LW, OP_SW, OP_ADDI: alu_op = ALU_ADD;
      OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      OP_SLTI:        alu_op = ALU_SLT;
      OP_ANDI: begin alu_op = ALU_AND; zero_extend = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  zero_extend = 1'b1; end
      OP_XORI: begin alu_op = ALU_XOR; zero_extend = 1'b1; end
      OP_LUI:         alu_op = ALU_LUI;
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared
// ready-handshaked memory port, with memory wait timeout, sticky HALT on the
// exit syscall, sticky FAULT on illegal instructions, and a saturating
// retired-instruction counter.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32,
  parameter int ALUOP_W      = 4
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              halted_q, fault_q;
  ctrl_t             c;

  alu_op_e dec_alu_op;
  logic    dec_zext, dec_illegal;

  mc_alu_decode u_alu_decode (
    .op         (bus.op),
    .funct      (bus.funct),
    .alu_op     (dec_alu_op),
    .zero_extend(dec_zext),
    .illegal    (dec_illegal)
  );

  logic is_rtype, is_jr, is_sys, is_jump, is_lw, is_sw, is_branch;
  logic mem_req, timeout, retire;

  assign is_rtype  = (bus.op == OP_RTYPE);
  assign is_jr     = is_rtype && (bus.funct == FN_JR);
  assign is_sys    = is_rtype && (bus.funct == FN_SYSCALL);
  assign is_jump   = (bus.op == OP_J) || (bus.op == OP_JAL);
  assign is_lw     = (bus.op == OP_LW);
  assign is_sw     = (bus.op == OP_SW);
  assign is_branch = (bus.op == OP_BEQ) || (bus.op == OP_BNE);

  // A request is outstanding in FETCH and MEM; ready is ignored elsewhere.
  assign mem_req = (state_q == S_FETCH) || (state_q == S_MEM);
  // Ready in the limit cycle still completes the request.
  assign timeout = (MEM_WAIT_MAX != 0) && mem_req && !bus.mem_ready &&
                   (wait_q == WAIT_W'(MEM_WAIT_MAX));
  // Completed instructions return to FETCH; the exit syscall retires into HALT.
  assign retire  = ((state_d == S_FETCH) &&
                    (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB})) ||
                   ((state_d == S_HALT) && (state_q != S_HALT));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (timeout)            state_d = S_FAULT;
        else if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_illegal)          state_d = S_FAULT;
        else if (is_jump || is_jr) state_d = S_FETCH;
        else if (is_sys)          state_d = bus.syscall_exit ? S_HALT : S_FETCH;
        else                      state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_lw || is_sw)  state_d = S_MEM;
        else if (is_branch)  state_d = S_FETCH;
        else                 state_d = S_WB;
      end
      S_MEM: begin
        if (timeout)            state_d = S_FAULT;
        else if (bus.mem_ready) state_d = is_lw ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Memory wait-state counter: counts stalled request cycles, clears on ready.
  always_ff @(posedge clk) begin
    if (rst || !mem_req || bus.mem_ready || (MEM_WAIT_MAX == 0)) wait_q <= '0;
    else if (!timeout)                                           wait_q <= wait_q + WAIT_W'(1);
  end

  // Retire counter and sticky halt/fault flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      if (retire && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      if (state_d == S_HALT)       halted_q <= 1'b1;
      if (state_d == S_FAULT)      fault_q  <= 1'b1;
    end
  end

  // Control strobes decoded from state and instruction fields.
  always_comb begin
    c = '0;
    case (state_q)
      S_FETCH: begin
        c.mem_read = 1'b1;
        if (bus.mem_ready) begin
          c.ir_write  = 1'b1;
          c.pc_write  = 1'b1;
          c.pc_src    = PC_ALU;
          c.alu_src_b = SRCB_FOUR;
          c.alu_op    = ALU_ADD;
        end
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALU_ADD;
        if (is_jump) begin
          c.pc_write = 1'b1;
          c.pc_src   = PC_JUMP;
          if (bus.op == OP_JAL) begin
            c.reg_write = 1'b1;
            c.is_jal    = 1'b1;
          end
        end else if (is_jr) begin
          c.pc_write = 1'b1;
          c.pc_src   = PC_RS;
        end
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        if (is_rtype) begin
          c.alu_src_b = SRCB_RT;
          c.alu_op    = dec_alu_op;
        end else if (is_lw || is_sw) begin
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALU_ADD;
        end else if (is_branch) begin
          c.alu_src_b     = SRCB_RT;
          c.alu_op        = ALU_SUB;
          c.pc_write_cond = 1'b1;
          c.pc_src        = PC_ALUOUT;
          c.bne_or_beq    = bus.op[0];
        end else begin
          c.alu_src_b   = SRCB_IMM;
          c.alu_op      = dec_alu_op;
          c.zero_extend = dec_zext;
        end
      end
      S_MEM: begin
        c.iord      = 1'b1;
        c.mem_read  = is_lw;
        c.mem_write = is_sw;
      end
      S_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = is_rtype;
        c.mem_to_reg = is_lw;
      end
      default: c = '0;
    endcase
    if (rst) c = '0;
  end

  assign bus.pc_write      = c.pc_write;
  assign bus.pc_write_cond = c.pc_write_cond;
  assign bus.bne_or_beq    = c.bne_or_beq;
  assign bus.pc_src        = c.pc_src;
  assign bus.ir_write      = c.ir_write;
  assign bus.iord          = c.iord;
  assign bus.mem_read      = c.mem_read;
  assign bus.mem_write     = c.mem_write;
  assign bus.reg_write     = c.reg_write;
  assign bus.reg_dst       = c.reg_dst;
  assign bus.mem_to_reg    = c.mem_to_reg;
  assign bus.is_jal        = c.is_jal;
  assign bus.alu_src_a     = c.alu_src_a;
  assign bus.alu_src_b     = c.alu_src_b;
  assign bus.zero_extend   = c.zero_extend;
  assign bus.alu_op        = ALUOP_W'(c.alu_op);
  assign bus.halted        = halted_q && !rst;
  assign bus.fault         = fault_q && !rst;
  assign bus.instr_count   = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction pushes its
// expected per-cycle control word, mem_ready value and retire count to a
// scoreboard queue; the queue is then drained one clock per entry and each
// entry is compared against the DUT outputs at the falling edge.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  localparam int WAIT_MAX = 3;
  localparam int CW       = 3;   // narrow counter so saturation is reachable
  localparam int CNT_SAT  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(CW), .ALUOP_W(4)) bus ();

  multicycle_control #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_W(CW), .ALUOP_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       pc_write, pc_write_cond, bne_or_beq;
    logic [1:0] pc_src;
    logic       ir_write, iord, mem_read, mem_write, reg_write, reg_dst;
    logic       mem_to_reg, is_jal, alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_extend;
    logic [3:0] alu_op;
    logic       halted, fault;
  } word_t;

  typedef struct {
    logic  rdy;
    word_t w;
    int    cnt;
    string tag;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    retired  = 0;
  string cur      = "";

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t obs();
    word_t w;
    w.pc_write      = bus.pc_write;
    w.pc_write_cond = bus.pc_write_cond;
    w.bne_or_beq    = bus.bne_or_beq;
    w.pc_src        = bus.pc_src;
    w.ir_write      = bus.ir_write;
    w.iord          = bus.iord;
    w.mem_read      = bus.mem_read;
    w.mem_write     = bus.mem_write;
    w.reg_write     = bus.reg_write;
    w.reg_dst       = bus.reg_dst;
    w.mem_to_reg    = bus.mem_to_reg;
    w.is_jal        = bus.is_jal;
    w.alu_src_a     = bus.alu_src_a;
    w.alu_src_b     = bus.alu_src_b;
    w.zero_extend   = bus.zero_extend;
    w.alu_op        = bus.alu_op;
    w.halted        = bus.halted;
    w.fault         = bus.fault;
    return w;
  endfunction

  // Expected control words, written from the instruction-level behaviour.
  function automatic word_t w_fetch(input logic rdy);
    word_t w = '0;
    w.mem_read = 1'b1;
    if (rdy) begin
      w.ir_write  = 1'b1;
      w.pc_write  = 1'b1;
      w.alu_src_b = 2'b01;
    end
    return w;
  endfunction

  function automatic word_t w_dec();
    word_t w = '0;
    w.alu_src_b = 2'b11;
    return w;
  endfunction

  function automatic word_t w_exec(input logic [1:0] srcb, input logic [3:0] aop, input logic zx);
    word_t w = '0;
    w.alu_src_a   = 1'b1;
    w.alu_src_b   = srcb;
    w.alu_op      = aop;
    w.zero_extend = zx;
    return w;
  endfunction

  function automatic word_t w_mem(input logic wr);
    word_t w = '0;
    w.iord      = 1'b1;
    w.mem_read  = !wr;
    w.mem_write = wr;
    return w;
  endfunction

  function automatic word_t w_wb(input logic rd, input logic m2r);
    word_t w = '0;
    w.reg_write  = 1'b1;
    w.reg_dst    = rd;
    w.mem_to_reg = m2r;
    return w;
  endfunction

  function automatic word_t w_stop(input logic h, input logic f);
    word_t w = '0;
    w.halted = h;
    w.fault  = f;
    return w;
  endfunction

  task automatic push(input logic rdy, input word_t w);
    item_t it;
    it.rdy = rdy;
    it.w   = w;
    it.cnt = (retired > CNT_SAT) ? CNT_SAT : retired;
    it.tag = cur;
    sb.push_back(it);
  endtask

  task automatic push_fetch(input int waits);
    for (int i = 0; i < waits; i++) push(1'b0, w_fetch(1'b0));
    push(1'b1, w_fetch(1'b1));
  endtask

  // Entered just after a rising edge; consumes one clock per entry.
  task automatic run();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      bus.mem_ready = it.rdy;
      @(negedge clk);
      check({it.tag, " ctrl"}, 64'(obs()), 64'(it.w));
      check({it.tag, " count"}, 64'(bus.instr_count), 64'(it.cnt));
      @(posedge clk); #1;
    end
  endtask

  task automatic set_instr(input string name, input logic [5:0] op, input logic [5:0] fn, input logic sx);
    cur              = name;
    bus.op           = op;
    bus.funct        = fn;
    bus.syscall_exit = sx;
  endtask

  task automatic do_reset(input string name);
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check({name, " ctrl in reset"}, 64'(obs()), 64'(word_t'('0)));
    check({name, " count in reset"}, 64'(bus.instr_count), 64'd0);
    @(posedge clk); #1;
    rst     = 1'b0;
    retired = 0;
  endtask

  task automatic t_rtype(input string name, input logic [5:0] fn, input logic [3:0] aop);
    set_instr(name, OP_RTYPE, fn, 1'b0);
    push_fetch(0); push(1'b1, w_dec()); push(1'b1, w_exec(2'b00, aop, 1'b0));
    push(1'b1, w_wb(1'b1, 1'b0));
    run(); retired++;
  endtask

  task automatic t_imm(input string name, input logic [5:0] op, input logic [3:0] aop, input logic zx);
    set_instr(name, op, 6'b010101, 1'b0);
    push_fetch(0); push(1'b1, w_dec()); push(1'b1, w_exec(2'b10, aop, zx));
    push(1'b1, w_wb(1'b0, 1'b0));
    run(); retired++;
  endtask

  task automatic t_branch(input string name, input logic [5:0] op);
    word_t w;
    set_instr(name, op, 6'b000000, 1'b0);
    w = w_exec(2'b00, ALU_SUB, 1'b0);
    w.pc_write_cond = 1'b1;
    w.pc_src        = 2'b01;
    w.bne_or_beq    = (op == OP_BNE);
    push_fetch(0); push(1'b1, w_dec()); push(1'b1, w);
    run(); retired++;
  endtask

  task automatic t_jump(input string name, input logic [5:0] op, input logic [5:0] fn);
    word_t w;
    set_instr(name, op, fn, 1'b0);
    w = w_dec();
    w.pc_write = 1'b1;
    w.pc_src   = (op == OP_RTYPE) ? 2'b11 : 2'b10;
    if (op == OP_JAL) begin
      w.reg_write = 1'b1;
      w.is_jal    = 1'b1;
    end
    push_fetch(0); push(1'b1, w);
    run(); retired++;
  endtask

  task automatic t_load(input string name, input int fwait, input int mwait);
    set_instr(name, OP_LW, 6'b000000, 1'b0);
    push_fetch(fwait); push(1'b1, w_dec()); push(1'b1, w_exec(2'b10, ALU_ADD, 1'b0));
    for (int i = 0; i < mwait; i++) push(1'b0, w_mem(1'b0));
    push(1'b1, w_mem(1'b0)); push(1'b1, w_wb(1'b0, 1'b1));
    run(); retired++;
  endtask

  task automatic t_store(input string name, input int mwait);
    set_instr(name, OP_SW, 6'b000000, 1'b0);
    push_fetch(0); push(1'b1, w_dec()); push(1'b1, w_exec(2'b10, ALU_ADD, 1'b0));
    for (int i = 0; i < mwait; i++) push(1'b0, w_mem(1'b1));
    push(1'b1, w_mem(1'b1));
    run(); retired++;
  endtask

  task automatic t_illegal(input string name, input logic [5:0] op, input logic [5:0] fn);
    set_instr(name, op, fn, 1'b0);
    push_fetch(0); push(1'b1, w_dec());
    for (int i = 0; i < 3; i++) push(1'b1, w_stop(1'b0, 1'b1));
    run();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.op = '0; bus.funct = '0; bus.mem_ready = 1'b0; bus.syscall_exit = 1'b0;
    @(posedge clk); #1;
    do_reset("power-on");

    // Main instruction mix; mem_ready is driven 1 outside requests.
    t_rtype("add", FN_ADD, ALU_ADD);
    t_load("lw wait=max", 2, WAIT_MAX);
    t_branch("bne", OP_BNE);
    t_branch("beq", OP_BEQ);
    t_jump("j", OP_J, 6'b000000);
    t_jump("jal", OP_JAL, 6'b000000);
    t_jump("jr", OP_RTYPE, FN_JR);
    t_imm("addi", OP_ADDI, ALU_ADD, 1'b0);
    t_imm("slti", OP_SLTI, ALU_SLT, 1'b0);
    t_imm("andi", OP_ANDI, ALU_AND, 1'b1);
    t_imm("ori", OP_ORI, ALU_OR, 1'b1);
    t_imm("xori", OP_XORI, ALU_XOR, 1'b1);
    t_imm("lui", OP_LUI, ALU_LUI, 1'b0);
    t_store("sw wait=1", 1);
    t_rtype("sub", FN_SUB, ALU_SUB);
    t_rtype("sra", FN_SRA, ALU_SRA);
    set_instr("syscall no-exit", OP_RTYPE, FN_SYSCALL, 1'b0);
    push_fetch(0); push(1'b1, w_dec()); run(); retired++;
    t_rtype("nor after saturate", FN_NOR, ALU_NOR);

    // Store whose memory never answers: faults after WAIT_MAX+1 request cycles.
    do_reset("pre-timeout");
    t_rtype("add before timeout", FN_ADD, ALU_ADD);
    set_instr("sw timeout", OP_SW, 6'b000000, 1'b0);
    push_fetch(0); push(1'b1, w_dec()); push(1'b1, w_exec(2'b10, ALU_ADD, 1'b0));
    for (int i = 0; i <= WAIT_MAX; i++) push(1'b0, w_mem(1'b1));
    for (int i = 0; i < 4; i++) push(1'b1, w_stop(1'b0, 1'b1));
    run();

    // Exit syscall: counted, then HALT absorbs with all strobes low.
    do_reset("post-timeout");
    t_rtype("slt", FN_SLT, ALU_SLT);
    set_instr("syscall exit", OP_RTYPE, FN_SYSCALL, 1'b1);
    push_fetch(0); push(1'b1, w_dec());
    retired++;
    for (int i = 0; i < 10; i++) push(1'b1, w_stop(1'b1, 1'b0));
    run();

    do_reset("post-halt");
    t_rtype("sll after halt", FN_SLL, ALU_SLL);
    t_illegal("illegal op", 6'b111111, 6'b000000);

    do_reset("post-illegal-op");
    t_illegal("illegal funct", OP_RTYPE, 6'b000001);

    // Reset arriving while a load is stalled in MEM.
    do_reset("post-illegal-funct");
    set_instr("lw aborted", OP_LW, 6'b000000, 1'b0);
    push_fetch(0); push(1'b1, w_dec()); push(1'b1, w_exec(2'b10, ALU_ADD, 1'b0));
    push(1'b0, w_mem(1'b0)); push(1'b0, w_mem(1'b0));
    run();
    do_reset("mid-mem");
    t_rtype("add after abort", FN_ADD, ALU_ADD);
    t_rtype("or final", FN_OR, ALU_OR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
